// File: rtl/tl_a_channel_queue.sv
// tl_a_channel_queue: parametrised TileLink A-channel FIFO with optional FLOW bypass and PIPE enqueue.
// Define TL_QUEUE_HIGH_WATER_EN to add the hwm / hwm_clr occupancy high-water mark.
module tl_a_channel_queue #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 64,
    parameter int SOURCE_W = 8,
    parameter int SIZE_W   = 4,
    parameter bit FLOW     = 1'b0,
    parameter bit PIPE     = 1'b0,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [2:0]            enq_opcode,
    input  logic [2:0]            enq_param,
    input  logic [SIZE_W-1:0]     enq_size,
    input  logic [SOURCE_W-1:0]   enq_source,
    input  logic [ADDR_W-1:0]     enq_address,
    input  logic [DATA_W/8-1:0]   enq_mask,
    input  logic [DATA_W-1:0]     enq_data,
    input  logic                  enq_corrupt,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic [2:0]            deq_opcode,
    output logic [2:0]            deq_param,
    output logic [SIZE_W-1:0]     deq_size,
    output logic [SOURCE_W-1:0]   deq_source,
    output logic [ADDR_W-1:0]     deq_address,
    output logic [DATA_W/8-1:0]   deq_mask,
    output logic [DATA_W-1:0]     deq_data,
    output logic                  deq_corrupt,
    output logic [CNT_W-1:0]      count
`ifdef TL_QUEUE_HIGH_WATER_EN
    ,
    output logic [CNT_W-1:0]      hwm,
    input  logic                  hwm_clr
`endif
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MASK_W = DATA_W / 8;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic [MASK_W-1:0]   mask;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             enq_entry;
    entry_t             head;
    logic [PTR_W-1:0]   enq_ptr;
    logic [PTR_W-1:0]   deq_ptr;
    logic               maybe_full;
    logic               ptr_match;
    logic               empty;
    logic               full;
    logic               bypass;
    logic               enq_fire;
    logic               deq_fire;
    logic               do_enq;
    logic               do_deq;
    logic [CNT_W-1:0]   enq_c;
    logic [CNT_W-1:0]   deq_c;

    // Wrap explicitly so non-power-of-2 depths work; DEPTH=1 pins both pointers at 0.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign enq_entry = {enq_opcode, enq_param, enq_size, enq_source,
                        enq_address, enq_mask, enq_data, enq_corrupt};

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match & ~maybe_full;
    assign full      = ptr_match & maybe_full;
    assign bypass    = FLOW && empty;

    assign enq_ready = ~full | (PIPE && deq_ready);
    assign deq_valid = ~empty | (FLOW && enq_valid);
    assign head      = bypass ? enq_entry : mem[deq_ptr];

    assign {deq_opcode, deq_param, deq_size, deq_source,
            deq_address, deq_mask, deq_data, deq_corrupt} = head;

    assign enq_fire = enq_valid & enq_ready;
    assign deq_fire = deq_valid & deq_ready;
    // A bypassed beat leaves straight through: nothing is stored and no pointer moves.
    assign do_enq   = enq_fire & ~(bypass & deq_ready);
    assign do_deq   = deq_fire & ~empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (do_enq) enq_ptr <= next_ptr(enq_ptr);
            if (do_deq) deq_ptr <= next_ptr(deq_ptr);
            if (do_enq != do_deq) maybe_full <= do_enq;
        end
    end

    always_ff @(posedge clock) begin
        if (do_enq & ~reset) mem[enq_ptr] <= enq_entry;
    end

    assign enq_c = CNT_W'(enq_ptr);
    assign deq_c = CNT_W'(deq_ptr);
    assign count = full             ? CNT_W'(DEPTH) :
                   (enq_c >= deq_c) ? enq_c - deq_c :
                                      enq_c + CNT_W'(DEPTH) - deq_c;

`ifdef TL_QUEUE_HIGH_WATER_EN
    always_ff @(posedge clock) begin
        if (reset)             hwm <= '0;
        else if (hwm_clr)      hwm <= count;
        else if (count > hwm)  hwm <= count;
    end
`endif

endmodule

// File: tb/tb_tl_a_channel_queue.sv
// Bench for tl_a_channel_queue: three configurations (D4 base, D3 base, D4 FLOW+PIPE), each with a
// directed + random driver and a scoreboard monitor checked against a queue-based reference model.
module tb_tl_a_channel_queue;
    localparam int PW = 105;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int D  = (g == 1) ? 3 : 4;
        localparam bit FL = (g == 2);
        localparam bit PP = (g == 2);
        localparam int CW = $clog2(D + 1);

        logic          reset, enq_valid, enq_ready, deq_valid, deq_ready;
        logic [PW-1:0] enq_pl, deq_pl;
        logic [CW-1:0] count;
        bit            done = 1'b0;
`ifdef TL_QUEUE_HIGH_WATER_EN
        logic [CW-1:0] hwm;
        logic          hwm_clr;
        int            exp_hwm;
`endif

        tl_a_channel_queue #(.DEPTH(D), .ADDR_W(14), .DATA_W(64), .SOURCE_W(8), .SIZE_W(4),
                             .FLOW(FL), .PIPE(PP)) dut (
            .clock(clock), .reset(reset),
            .enq_valid(enq_valid), .enq_ready(enq_ready),
            .enq_opcode(enq_pl[104:102]), .enq_param(enq_pl[101:99]), .enq_size(enq_pl[98:95]),
            .enq_source(enq_pl[94:87]), .enq_address(enq_pl[86:73]), .enq_mask(enq_pl[72:65]),
            .enq_data(enq_pl[64:1]), .enq_corrupt(enq_pl[0]),
            .deq_valid(deq_valid), .deq_ready(deq_ready),
            .deq_opcode(deq_pl[104:102]), .deq_param(deq_pl[101:99]), .deq_size(deq_pl[98:95]),
            .deq_source(deq_pl[94:87]), .deq_address(deq_pl[86:73]), .deq_mask(deq_pl[72:65]),
            .deq_data(deq_pl[64:1]), .deq_corrupt(deq_pl[0]),
            .count(count)
`ifdef TL_QUEUE_HIGH_WATER_EN
            , .hwm(hwm), .hwm_clr(hwm_clr)
`endif
        );

        // Reference: a plain queue of accepted beats; occupancy is its size.
        logic [PW-1:0] mq[$];
        logic [PW-1:0] expd;
        int            n;
        bit            er, dv;

        always @(negedge clock) begin
            if (reset) begin
                mq.delete();
`ifdef TL_QUEUE_HIGH_WATER_EN
                exp_hwm = 0;
`endif
            end else begin
                n  = mq.size();
                er = (n < D) || (PP && deq_ready);
                dv = (n > 0) || (FL && enq_valid);
                check($sformatf("cfg%0d count", g), count, n);
                check($sformatf("cfg%0d enq_ready", g), enq_ready, er);
                check($sformatf("cfg%0d deq_valid", g), deq_valid, dv);
`ifdef TL_QUEUE_HIGH_WATER_EN
                check($sformatf("cfg%0d hwm", g), hwm, exp_hwm);
                if (hwm_clr) exp_hwm = n;
                else if (n > exp_hwm) exp_hwm = n;
`endif
                if (dv && deq_ready) begin
                    expd = (n > 0) ? mq[0] : enq_pl;
                    check($sformatf("cfg%0d deq payload", g), deq_pl, expd);
                    if (n > 0) void'(mq.pop_front());
                end
                if (enq_valid && er && !(FL && n == 0 && deq_ready)) mq.push_back(enq_pl);
            end
        end

        function automatic logic [PW-1:0] mk(input logic [63:0] data);
            return {3'd4, 3'd0, 4'd3, 8'(g), 14'h100, 8'hFF, data, 1'b0};
        endfunction

        task automatic tick();
            @(posedge clock);
            #1;
        endtask

        task automatic drain();
            enq_valid = 1'b0;
            deq_ready = 1'b1;
            repeat (D + 1) tick();
            deq_ready = 1'b0;
        endtask

        initial begin
            reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; enq_pl = '0;
`ifdef TL_QUEUE_HIGH_WATER_EN
            hwm_clr = 1'b0;
`endif
            repeat (2) tick();
            check($sformatf("cfg%0d reset count", g), count, 0);
            check($sformatf("cfg%0d reset enq_ready", g), enq_ready, 1);
            reset = 1'b0;

            // Fill past capacity with the consumer stalled; the extra beat must be refused.
            enq_valid = 1'b1;
            for (int i = 0; i <= D; i++) begin
                enq_pl = mk(64'(8'h11 * (i + 1)));
                #1 check($sformatf("cfg%0d fill enq_ready", g), enq_ready, i < D);
                tick();
                check($sformatf("cfg%0d fill count", g), count, (i < D) ? i + 1 : D);
            end
            drain();
            check($sformatf("cfg%0d drained count", g), count, 0);
            check($sformatf("cfg%0d drained deq_valid", g), deq_valid, 0);

            // Streaming: one beat ahead, then enq+deq every cycle across the pointer wrap.
            enq_valid = 1'b1;
            enq_pl = mk(64'h100);
            tick();
            deq_ready = 1'b1;
            for (int i = 1; i <= 10; i++) begin
                enq_pl = mk(64'(32'h100 + i));
                tick();
                check($sformatf("cfg%0d stream count", g), count, 1);
            end
            drain();

            // Full, then simultaneous enq+deq.
            enq_valid = 1'b1;
            for (int i = 0; i < D; i++) begin
                enq_pl = mk(64'(32'h200 + i));
                tick();
            end
            deq_ready = 1'b1;
            enq_pl = mk(64'h2FF);
            #1 check($sformatf("cfg%0d full enq_ready", g), enq_ready, PP);
            tick();
            enq_valid = 1'b0;
            deq_ready = 1'b0;
            #1 check($sformatf("cfg%0d full simul count", g), count, PP ? D : D - 1);
            drain();

            // Empty queue, producer and consumer both ready.
            enq_valid = 1'b1;
            deq_ready = 1'b1;
            enq_pl = mk(64'hAB);
            #1 check($sformatf("cfg%0d flow deq_valid", g), deq_valid, FL);
            if (FL) check($sformatf("cfg%0d flow deq_data", g), deq_pl[64:1], 64'hAB);
            tick();
            enq_valid = 1'b0;
            deq_ready = 1'b0;
            #1 check($sformatf("cfg%0d flow count", g), count, FL ? 0 : 1);
            drain();

            for (int i = 0; i < 400; i++) begin
                reset     = ($urandom_range(0, 79) == 0);
                enq_valid = $urandom_range(0, 1);
                deq_ready = ($urandom_range(0, 2) != 0);
                enq_pl    = PW'({$urandom(), $urandom(), $urandom(), $urandom()});
`ifdef TL_QUEUE_HIGH_WATER_EN
                hwm_clr   = ($urandom_range(0, 15) == 0);
`endif
                tick();
            end
            reset = 1'b0;
`ifdef TL_QUEUE_HIGH_WATER_EN
            hwm_clr = 1'b0;
`endif
            drain();

            // Reset with two beats queued and a transfer in flight.
            enq_valid = 1'b1;
            for (int i = 0; i < 2; i++) begin
                enq_pl = mk(64'(32'h300 + i));
                tick();
            end
            check($sformatf("cfg%0d pre-reset count", g), count, 2);
            reset = 1'b1;
            deq_ready = 1'b1;
            tick();
            reset = 1'b0;
            enq_valid = 1'b0;
            deq_ready = 1'b0;
            #1;
            check($sformatf("cfg%0d post-reset count", g), count, 0);
            check($sformatf("cfg%0d post-reset deq_valid", g), deq_valid, 0);
            check($sformatf("cfg%0d post-reset enq_ready", g), enq_ready, 1);
`ifdef TL_QUEUE_HIGH_WATER_EN
            check($sformatf("cfg%0d post-reset hwm", g), hwm, 0);
`endif
            repeat (2) tick();
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(u[0].done && u[1].done && u[2].done); i++)
            @(posedge clock);
        if (!(u[0].done && u[1].done && u[2].done)) begin
            checks++;
            fails++;
            $display("FAIL timeout: drivers done=%0b%0b%0b required 111", u[0].done, u[1].done, u[2].done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
